qs_enq: RTL and testbench

//   Ingress end of the qs sorter: accepts an unsorted packet stream (sop/eop

---
 rtl/qs_pkg.sv | 41 ++++
 rtl/qs_enq.sv | 182 ++++++++++++++++++
 tb/tb_qs_enq.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// qs_pkg: shared types, sizes and helpers for the qs sorter.
//   W        data word width
//   N        words per bank
//   BANKS_N  number of banks
//   w_t, addr_t, bank_id_t, bank_status_t, bank_state_t, bank_id_inc()
package qs_pkg;

   localparam int unsigned W         = 32;
   localparam int unsigned N         = 16;
   localparam int unsigned BANKS_N   = 2;
   localparam int unsigned ADDR_W    = $clog2(N);
   localparam int unsigned BANK_ID_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1;

   typedef logic [W-1:0]         w_t;
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [BANK_ID_W-1:0] bank_id_t;

   typedef enum logic [2:0] {
      BANK_IDLE      = 3'd0,
      BANK_LOADING   = 3'd1,
      BANK_READY     = 3'd2,
      BANK_SORTING   = 3'd3,
      BANK_SORTED    = 3'd4,
      BANK_UNLOADING = 3'd5
   } bank_status_t;

   // n is the index of the last valid word in the bank (length - 1).
   typedef struct packed {
      bank_status_t status;
      addr_t        n;
   } bank_state_t;

   // Round-robin successor, wrapping BANKS_N-1 back to 0.
   function automatic bank_id_t bank_id_inc(input bank_id_t id);
      if (id == bank_id_t'(BANKS_N - 1)) begin
         return '0;
      end
      return id + bank_id_t'(1);
   endfunction

endpackage

// File: rtl/qs_enq.sv
// qs_enq: ingress end of the qs sorter. Accepts a sop/eop framed packet
// stream, writes it word by word into the selected bank, marks the bank
// BANK_READY on completion and advances round-robin to the next bank.
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   in_vld        input beat valid
//   in_sop        first word of packet
//   in_eop        last word of packet
//   in_dat        input word
//   in_rdy_r      beat accepted when in_vld & in_rdy_r (registered)
//   err_r         one-cycle pulse on protocol/overflow error
//   bank_idx_r    bank currently being loaded
//   bank_in       scoreboard entry of bank_idx_r
//   bank_out_vld  write bank_out to the scoreboard this cycle (combinational)
//   bank_out      updated scoreboard entry
//   wr_en_r       bank write strobe
//   wr_addr_r     bank write address
//   wr_data_r     bank write data
module qs_enq
   import qs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_vld,
   input  logic        in_sop,
   input  logic        in_eop,
   input  w_t          in_dat,
   output logic        in_rdy_r,
   output logic        err_r,
   output bank_id_t    bank_idx_r,
   input  bank_state_t bank_in,
   output logic        bank_out_vld,
   output bank_state_t bank_out,
   output logic        wr_en_r,
   output addr_t       wr_addr_r,
   output w_t          wr_data_r
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDiscard,
      StCommit
   } fsm_t;

   localparam addr_t LastAddr = addr_t'(N - 1);

   fsm_t     state_q, state_d;
   addr_t    wr_ptr_q, wr_ptr_d;
   addr_t    n_q, n_d;
   // A bank holds a truncated packet that must still be committed.
   logic     open_q, open_d;
   bank_id_t bank_idx_d;
   logic     in_rdy_d;
   logic     err_d;
   logic     wr_en_d;
   addr_t    wr_addr_d;
   w_t       wr_data_d;
   logic     accept;

   // The entry's n field carries no information for the ingress side.
   logic     unused_bank_n;
   assign unused_bank_n = ^bank_in.n;

   assign accept = in_vld & in_rdy_r;

   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      n_d             = n_q;
      open_d          = open_q;
      bank_idx_d      = bank_idx_r;
      err_d           = 1'b0;
      wr_en_d         = 1'b0;
      wr_addr_d       = wr_addr_r;
      wr_data_d       = wr_data_r;
      bank_out_vld    = 1'b0;
      bank_out.status = BANK_LOADING;
      bank_out.n      = n_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_sop) begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = '0;
                  wr_data_d    = in_dat;
                  wr_ptr_d     = addr_t'(1);
                  n_d          = '0;
                  open_d       = 1'b1;
                  bank_out.n   = '0;
                  bank_out_vld = 1'b1;
                  state_d      = in_eop ? StCommit : StLoad;
               end else begin
                  // Headless beat: drop it and everything up to its eop.
                  err_d = 1'b1;
                  if (!in_eop) begin
                     state_d = StDiscard;
                  end
               end
            end
         end
         StLoad: begin
            if (accept) begin
               wr_en_d      = 1'b1;
               wr_addr_d    = wr_ptr_q;
               wr_data_d    = in_dat;
               n_d          = wr_ptr_q;
               bank_out.n   = wr_ptr_q;
               bank_out_vld = 1'b1;
               wr_ptr_d     = wr_ptr_q + addr_t'(1);
               // A stray sop mid-packet is flagged but kept as data.
               if (in_sop) begin
                  err_d = 1'b1;
               end
               if (in_eop) begin
                  state_d = StCommit;
               end else if (wr_ptr_q == LastAddr) begin
                  // Bank full: truncate here, commit once the tail is drained.
                  err_d   = 1'b1;
                  state_d = StDiscard;
               end
            end
         end
         StDiscard: begin
            if (accept && in_eop) begin
               state_d = open_q ? StCommit : StIdle;
            end
         end
         StCommit: begin
            bank_out.status = BANK_READY;
            bank_out_vld    = 1'b1;
            bank_idx_d      = bank_id_inc(bank_idx_r);
            wr_ptr_d        = '0;
            open_d          = 1'b0;
            state_d         = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Ready in IDLE is only granted after a full IDLE cycle, so bank_in
      // already reflects the newly selected bank after a commit.
      if ((state_d == StLoad) || (state_d == StDiscard)) begin
         in_rdy_d = 1'b1;
      end else if ((state_d == StIdle) && (state_q == StIdle)) begin
         in_rdy_d = (bank_in.status == BANK_IDLE);
      end else begin
         in_rdy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         n_q        <= '0;
         open_q     <= 1'b0;
         bank_idx_r <= '0;
         in_rdy_r   <= 1'b0;
         err_r      <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         n_q        <= n_d;
         open_q     <= open_d;
         bank_idx_r <= bank_idx_d;
         in_rdy_r   <= in_rdy_d;
         err_r      <= err_d;
         wr_en_r    <= wr_en_d;
         wr_addr_r  <= wr_addr_d;
         wr_data_r  <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_qs_enq.sv
// tb_qs_enq: directed bench for qs_enq. A small scoreboard model feeds
// bank_in from bank_out writes; a negedge monitor logs bank writes,
// scoreboard updates and error pulses for the scenario tasks to inspect.
module tb_qs_enq;
   import qs_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld, in_sop, in_eop;
   w_t          in_dat;
   logic        in_rdy_r, err_r;
   bank_id_t    bank_idx_r;
   bank_state_t bank_in, bank_out;
   logic        bank_out_vld, wr_en_r;
   addr_t       wr_addr_r;
   w_t          wr_data_r;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qs_enq dut (
      .clk          (clk),
      .rst          (rst),
      .in_vld       (in_vld),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_dat       (in_dat),
      .in_rdy_r     (in_rdy_r),
      .err_r        (err_r),
      .bank_idx_r   (bank_idx_r),
      .bank_in      (bank_in),
      .bank_out_vld (bank_out_vld),
      .bank_out     (bank_out),
      .wr_en_r      (wr_en_r),
      .wr_addr_r    (wr_addr_r),
      .wr_data_r    (wr_data_r)
   );

   // Scoreboard model; ovr_* lets the bench play the sort/unload side.
   bank_state_t  sb [BANKS_N];
   logic         ovr_en;
   bank_id_t     ovr_idx;
   bank_status_t ovr_status;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BANKS_N; i++) begin
            sb[i] <= '{status: BANK_IDLE, n: '0};
         end
      end else begin
         if (ovr_en) sb[ovr_idx].status <= ovr_status;
         if (bank_out_vld) sb[bank_idx_r] <= bank_out;
      end
   end

   assign bank_in = sb[bank_idx_r];

   addr_t       wr_addr_log [$];
   w_t          wr_data_log [$];
   bank_state_t bo_log      [$];
   int          err_cnt = 0;

   always @(negedge clk) begin
      if (wr_en_r) begin
         wr_addr_log.push_back(wr_addr_r);
         wr_data_log.push_back(wr_data_r);
      end
      if (bank_out_vld) bo_log.push_back(bank_out);
      if (err_r) err_cnt++;
   end

   function automatic bank_state_t mk(input bank_status_t st, input int n);
      bank_state_t s;
      s.status = st;
      s.n      = addr_t'(n);
      return s;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat; waits (bounded) for in_rdy_r, then holds it one edge.
   task automatic beat(input logic sop, input logic eop, input w_t d);
      int t;
      t = 0;
      in_vld = 1'b0;
      while (!in_rdy_r && t < 50) begin
         tick(1);
         t++;
      end
      if (!in_rdy_r) begin
         checks++;
         errors++;
         $display("FAIL beat_ready_timeout got in_rdy_r=%b need 1", in_rdy_r);
      end
      in_vld = 1'b1;
      in_sop = sop;
      in_eop = eop;
      in_dat = d;
      tick(1);
      in_vld = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
   endtask

   task automatic set_status(input bank_id_t idx, input bank_status_t st);
      ovr_en     = 1'b1;
      ovr_idx    = idx;
      ovr_status = st;
      tick(1);
      ovr_en     = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({in_rdy_r, err_r, wr_en_r, bank_out_vld} !== 4'b0000 || bank_idx_r !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy/err/wr/bov=%b%b%b%b idx=%0d need 0000 idx=0",
                  in_rdy_r, err_r, wr_en_r, bank_out_vld, bank_idx_r);
      end
      rst = 1'b1;
      tick(2);
      checks++;
      if (in_rdy_r !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after got %b need 1", in_rdy_r);
      end
   endtask

   task automatic test_four_word;
      int w0, b0, e0;
      w0 = wr_addr_log.size();
      b0 = bo_log.size();
      e0 = err_cnt;
      for (int i = 0; i < 4; i++) beat(i == 0, i == 3, w_t'(32'hA + i));
      tick(3);
      checks++;
      if (wr_addr_log.size() - w0 !== 4) begin
         errors++;
         $display("FAIL four_word_count got %0d need 4", wr_addr_log.size() - w0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_addr_log[w0+i] !== addr_t'(i) || wr_data_log[w0+i] !== w_t'(32'hA + i)) begin
            errors++;
            $display("FAIL four_word_write[%0d] got addr=%0d data=%h need addr=%0d data=%h",
                     i, wr_addr_log[w0+i], wr_data_log[w0+i], i, 32'hA + i);
         end
      end
      checks++;
      if (bo_log.size() - b0 !== 5 || bo_log[b0+3] !== mk(BANK_LOADING, 3)) begin
         errors++;
         $display("FAIL four_word_sb_updates got count=%0d entry3=%h need 5 %h",
                  bo_log.size() - b0, bo_log[b0+3], mk(BANK_LOADING, 3));
      end
      checks++;
      if (sb[0] !== mk(BANK_READY, 3)) begin
         errors++;
         $display("FAIL four_word_commit got %h need %h", sb[0], mk(BANK_READY, 3));
      end
      checks++;
      if (bank_idx_r !== bank_id_t'(1) || err_cnt != e0) begin
         errors++;
         $display("FAIL four_word_idx_err got idx=%0d errs=%0d need idx=1 errs=0",
                  bank_idx_r, err_cnt - e0);
      end
   endtask

   task automatic test_single_word;
      beat(1'b1, 1'b1, w_t'(32'h55));
      // Now in COMMIT: the write lands while READY goes to the scoreboard.
      checks++;
      if (wr_en_r !== 1'b1 || wr_addr_r !== '0 || wr_data_r !== w_t'(32'h55)) begin
         errors++;
         $display("FAIL single_write got en=%b addr=%0d data=%h need 1 0 00000055",
                  wr_en_r, wr_addr_r, wr_data_r);
      end
      checks++;
      if (bank_out_vld !== 1'b1 || bank_out !== mk(BANK_READY, 0) || in_rdy_r !== 1'b0) begin
         errors++;
         $display("FAIL single_commit got vld=%b out=%h rdy=%b need 1 %h 0",
                  bank_out_vld, bank_out, in_rdy_r, mk(BANK_READY, 0));
      end
      tick(2);
      checks++;
      if (sb[1] !== mk(BANK_READY, 0) || bank_idx_r !== '0) begin
         errors++;
         $display("FAIL single_sb got sb1=%h idx=%0d need %h idx=0",
                  sb[1], bank_idx_r, mk(BANK_READY, 0));
      end
   endtask

   task automatic test_overflow;
      int w0, e0;
      set_status(0, BANK_IDLE);
      w0 = wr_addr_log.size();
      e0 = err_cnt;
      for (int i = 0; i < 20; i++) begin
         beat(i == 0, i == 19, w_t'(32'h100 + i));
         if (i == 15) begin
            checks++;
            if (err_r !== 1'b1) begin
               errors++;
               $display("FAIL overflow_err_pulse got %b need 1", err_r);
            end
         end
      end
      tick(3);
      checks++;
      if (wr_addr_log.size() - w0 !== 16) begin
         errors++;
         $display("FAIL overflow_count got %0d need 16", wr_addr_log.size() - w0);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wr_addr_log[w0+i] !== addr_t'(i) || wr_data_log[w0+i] !== w_t'(32'h100 + i)) begin
            errors++;
            $display("FAIL overflow_write[%0d] got addr=%0d data=%h need addr=%0d data=%h",
                     i, wr_addr_log[w0+i], wr_data_log[w0+i], i, 32'h100 + i);
         end
      end
      checks++;
      if (sb[0] !== mk(BANK_READY, 15) || bank_idx_r !== bank_id_t'(1) || err_cnt - e0 != 1)
      begin
         errors++;
         $display("FAIL overflow_commit got sb0=%h idx=%0d errs=%0d need %h 1 1",
                  sb[0], bank_idx_r, err_cnt - e0, mk(BANK_READY, 15));
      end
   endtask

   task automatic test_no_sop;
      int w0, b0, e0;
      set_status(1, BANK_IDLE);
      w0 = wr_addr_log.size();
      b0 = bo_log.size();
      e0 = err_cnt;
      beat(1'b0, 1'b0, w_t'(32'h300));
      checks++;
      if (err_r !== 1'b1) begin
         errors++;
         $display("FAIL no_sop_err_pulse got %b need 1", err_r);
      end
      beat(1'b0, 1'b0, w_t'(32'h301));
      beat(1'b0, 1'b1, w_t'(32'h302));
      tick(3);
      checks++;
      if (wr_addr_log.size() != w0 || bo_log.size() != b0 || err_cnt - e0 != 1) begin
         errors++;
         $display("FAIL no_sop_dropped got writes=%0d sbw=%0d errs=%0d need 0 0 1",
                  wr_addr_log.size() - w0, bo_log.size() - b0, err_cnt - e0);
      end
      checks++;
      if (bank_idx_r !== bank_id_t'(1) || sb[1].status !== BANK_IDLE || in_rdy_r !== 1'b1) begin
         errors++;
         $display("FAIL no_sop_state got idx=%0d st=%0d rdy=%b need 1 0 1",
                  bank_idx_r, sb[1].status, in_rdy_r);
      end
   endtask

   task automatic test_back_to_back;
      int w0, stall_rdy;
      set_status(0, BANK_IDLE);
      beat(1'b1, 1'b0, w_t'(32'h200));
      beat(1'b0, 1'b1, w_t'(32'h201));
      tick(1);
      checks++;
      if (bank_idx_r !== '0 || sb[1] !== mk(BANK_READY, 1)) begin
         errors++;
         $display("FAIL b2b_wrap got idx=%0d sb1=%h need 0 %h",
                  bank_idx_r, sb[1], mk(BANK_READY, 1));
      end
      set_status(1, BANK_SORTED);
      w0 = wr_addr_log.size();
      for (int i = 0; i < 3; i++) beat(i == 0, i == 2, w_t'(32'h210 + i));
      tick(2);
      checks++;
      if (sb[0] !== mk(BANK_READY, 2) || wr_addr_log.size() - w0 !== 3 ||
          wr_addr_log[w0+2] !== addr_t'(2) || wr_data_log[w0+2] !== w_t'(32'h212)) begin
         errors++;
         $display("FAIL b2b_second got sb0=%h writes=%0d last=%0d/%h need %h 3 2/00000212",
                  sb[0], wr_addr_log.size() - w0, wr_addr_log[w0+2], wr_data_log[w0+2],
                  mk(BANK_READY, 2));
      end
      // Bank 1 is busy: a waiting packet must not be taken.
      w0 = wr_addr_log.size();
      stall_rdy = 0;
      in_vld = 1'b1;
      in_sop = 1'b1;
      in_eop = 1'b1;
      in_dat = w_t'(32'h999);
      for (int i = 0; i < 6; i++) begin
         if (in_rdy_r !== 1'b0) stall_rdy++;
         tick(1);
      end
      in_vld = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
      checks++;
      if (stall_rdy != 0 || wr_addr_log.size() != w0 || bank_idx_r !== bank_id_t'(1)) begin
         errors++;
         $display("FAIL busy_stall got rdy_cycles=%0d writes=%0d idx=%0d need 0 0 1",
                  stall_rdy, wr_addr_log.size() - w0, bank_idx_r);
      end
      set_status(1, BANK_IDLE);
      tick(1);
      checks++;
      if (in_rdy_r !== 1'b1) begin
         errors++;
         $display("FAIL busy_release got rdy=%b need 1", in_rdy_r);
      end
   endtask

   task automatic test_reset_mid_load;
      for (int i = 0; i < 5; i++) beat(i == 0, 1'b0, w_t'(32'h400 + i));
      checks++;
      if (wr_en_r !== 1'b1 || wr_addr_r !== addr_t'(4) || bank_idx_r !== bank_id_t'(1)) begin
         errors++;
         $display("FAIL mid_load_pre got en=%b addr=%0d idx=%0d need 1 4 1",
                  wr_en_r, wr_addr_r, bank_idx_r);
      end
      in_vld = 1'b1;
      in_dat = w_t'(32'h405);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({in_rdy_r, err_r, wr_en_r, bank_out_vld} !== 4'b0000 || bank_idx_r !== '0) begin
         errors++;
         $display("FAIL mid_load_reset got rdy/err/wr/bov=%b%b%b%b idx=%0d need 0000 idx=0",
                  in_rdy_r, err_r, wr_en_r, bank_out_vld, bank_idx_r);
      end
      in_vld = 1'b0;
      rst = 1'b1;
      tick(3);
      checks++;
      if (in_rdy_r !== 1'b1 || sb[0].status !== BANK_IDLE) begin
         errors++;
         $display("FAIL mid_load_recover got rdy=%b st=%0d need 1 0", in_rdy_r, sb[0].status);
      end
   endtask

   initial begin
      rst    = 1'b1;
      in_vld = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
      in_dat = '0;
      ovr_en = 1'b0;
      ovr_idx = '0;
      ovr_status = BANK_IDLE;
      #2;
      rst = 1'b0;
      tick(3);
      test_reset;
      test_four_word;
      test_single_word;
      test_overflow;
      test_no_sop;
      test_back_to_back;
      test_reset_mid_load;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
